neo_clkgen_sync: RTL and testbench
==================================

Name: neo_clkgen_sync

Overview:
- Clock-enable generator for the Neo-Geo video/CPU core. Runs entirely on the 48 MHz system clock.
- Derives the 24/12/6/3 MHz timing of the original clock divider and the 68K clock from the 24 MHz edge-enable pair.
- Outputs registered level copies of the derived clocks, plus single-CLK-cycle edge enables for synchronous consumers: LSPC bus logic, B1, ZMC2 and the 68K core.

Parameters:
- None.

Ports:
- CLK  in  1  48 MHz system clock; every register is clocked on its rising edge.
- nRESETP  in  1  asynchronous, active-low reset.
- CLK_EN_24M_P  in  1  one-CLK pulse marking a 24 MHz rising edge.
- CLK_EN_24M_N  in  1  one-CLK pulse marking a 24 MHz falling edge. Never high in the same cycle as CLK_EN_24M_P.
- CLK_24M  out  1  level 24 MHz clock reconstructed from the enables.
- CLK_12M  out  1  level 12 MHz (divider bit 0).
- CLK_68KCLK  out  1  level 12 MHz 68K clock.
- CLK_68KCLKB  out  1  inverse of CLK_68KCLK.
- CLK_EN_68K_P  out  1  pulse in the cycle where CLK_68KCLK rises.
- CLK_EN_68K_N  out  1  pulse in the cycle where CLK_68KCLK falls.
- CLK_6MB  out  1  inverted divider bit 1.
- CLK_1HB  out  1  half-line-pixel clock (1HB).
- CLK_EN_12M  out  1  pulse in the cycle where CLK_12M rises.
- CLK_EN_12M_N  out  1  pulse in the cycle where CLK_12M falls.
- CLK_EN_6MB  out  1  pulse in the cycle where CLK_6MB rises.
- CLK_EN_1HB  out  1  pulse in the cycle where CLK_1HB rises.

Behaviour:
- State: 3-bit counter DIV, plus registers R24, R68K and R1HB.
- Reset (nRESETP low, asynchronous):
  - DIV=3'b100, R24=0, R68K=0, R1HB=0.
  - Resulting outputs: CLK_12M=0, CLK_6MB=1, CLK_68KCLK=0, CLK_68KCLKB=1, CLK_1HB=0, CLK_24M=0.
  - All enable outputs are forced to 0 while reset is low.
- R24: set to 1 on CLK_EN_24M_P, cleared to 0 on CLK_EN_24M_N. CLK_24M=R24.
- DIV: incremented mod 8 on each CLK_EN_24M_N cycle; holds otherwise. 7 wraps to 0.
- Level outputs from DIV: CLK_12M=DIV[0], CLK_6MB=~DIV[1]. The internal 3 MHz signal is DIV[2].
- R68K: toggles on each CLK_EN_24M_P. CLK_68KCLK=R68K, CLK_68KCLKB=~R68K.
- R1HB: on a cycle with CLK_EN_24M_N and DIV[0]==0 (the 12M rising edge), R1HB <= ~DIV[2]. CLK_1HB=R1HB.
- Enables are combinational from the current state and inputs. They are high in the same CLK cycle in which the matching register updates, so the level changes one CLK later. Decodes:
  - CLK_EN_12M = EN_24M_N & ~DIV[0]
  - CLK_EN_12M_N = EN_24M_N & DIV[0]
  - CLK_EN_6MB = EN_24M_N & DIV[1] & DIV[0]
  - CLK_EN_68K_P = EN_24M_P & ~R68K
  - CLK_EN_68K_N = EN_24M_P & R68K
  - CLK_EN_1HB = EN_24M_N & ~DIV[0] & ~DIV[2] & ~R1HB
- Periods with enables alternating P/N every CLK:
  - 12M: 4 CLK; 6MB: 8 CLK; 3M: 16 CLK; 68KCLK: 4 CLK.
  - Every enable output is high for exactly 1 CLK per period.
- If neither input enable is high, all state holds and all enables are 0. Stalling the input enables stretches all derived clocks proportionally.
- Reset asserted mid-period: state reinitialises immediately. After release, the first CLK_EN_24M_N moves DIV 4→5 and raises CLK_12M.

Test Plan:
- Reset, then drive alternating P,N enables: first N pulse → CLK_EN_12M=1 in that cycle, CLK_12M=1 next cycle, DIV=5. CLK_EN_12M_N pulses every 4 CLK thereafter.
- Run 64 CLK after reset: count exactly 16 CLK_EN_12M, 16 CLK_EN_68K_P, 8 CLK_EN_6MB and 4 CLK_EN_1HB pulses. No two pulses of the same enable are adjacent.
- Check CLK_6MB == ~DIV[1] and CLK_EN_6MB coincides only with DIV==3 or DIV==7 on an N pulse. CLK_6MB rises exactly one CLK after each CLK_EN_6MB.
- Check CLK_68KCLKB is always ~CLK_68KCLK. CLK_EN_68K_P and CLK_EN_68K_N alternate, 2 CLK apart, both on P-pulse cycles only.
- Hold both input enables low for 10 CLK mid-run → all outputs frozen, zero enable pulses. Resume → sequence continues from the frozen DIV.
- Assert nRESETP low asynchronously between edges while DIV=6 → CLK_12M=0, CLK_6MB=1, CLK_1HB=0 immediately, enables 0. Restart matches the first scenario.

Source files
------------

// File: rtl/neo_clkgen_sync.sv
// Clock-enable generator for the Neo-Geo core: rebuilds the 24/12/6/3 MHz divider
// and the 68K clock from a 24 MHz edge-enable pair, all on the 48 MHz system clock.
module neo_clkgen_sync (
    input  logic CLK,
    input  logic nRESETP,
    input  logic CLK_EN_24M_P,
    input  logic CLK_EN_24M_N,
    output logic CLK_24M,
    output logic CLK_12M,
    output logic CLK_68KCLK,
    output logic CLK_68KCLKB,
    output logic CLK_EN_68K_P,
    output logic CLK_EN_68K_N,
    output logic CLK_6MB,
    output logic CLK_1HB,
    output logic CLK_EN_12M,
    output logic CLK_EN_12M_N,
    output logic CLK_EN_6MB,
    output logic CLK_EN_1HB
);

    logic [2:0] div_q, div_d;
    logic       r24_q, r24_d;
    logic       r68k_q, r68k_d;
    logic       r1hb_q, r1hb_d;

    always_comb begin
        div_d  = div_q;
        r24_d  = r24_q;
        r68k_d = r68k_q;
        r1hb_d = r1hb_q;
        if (CLK_EN_24M_P) begin
            r24_d  = 1'b1;
            r68k_d = ~r68k_q;
        end
        if (CLK_EN_24M_N) begin
            r24_d = 1'b0;
            div_d = div_q + 3'd1;
            // 1HB samples the 3 MHz phase on the 12M rising edge
            if (!div_q[0]) r1hb_d = ~div_q[2];
        end
    end

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            div_q  <= 3'b100;
            r24_q  <= 1'b0;
            r68k_q <= 1'b0;
            r1hb_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            r24_q  <= r24_d;
            r68k_q <= r68k_d;
            r1hb_q <= r1hb_d;
        end
    end

    assign CLK_24M     = r24_q;
    assign CLK_12M     = div_q[0];
    assign CLK_6MB     = ~div_q[1];
    assign CLK_68KCLK  = r68k_q;
    assign CLK_68KCLKB = ~r68k_q;
    assign CLK_1HB     = r1hb_q;

    // Enables fire in the cycle the matching register updates; masked while in reset
    assign CLK_EN_12M   = nRESETP & CLK_EN_24M_N & ~div_q[0];
    assign CLK_EN_12M_N = nRESETP & CLK_EN_24M_N & div_q[0];
    assign CLK_EN_6MB   = nRESETP & CLK_EN_24M_N & div_q[1] & div_q[0];
    assign CLK_EN_68K_P = nRESETP & CLK_EN_24M_P & ~r68k_q;
    assign CLK_EN_68K_N = nRESETP & CLK_EN_24M_P & r68k_q;
    assign CLK_EN_1HB   = nRESETP & CLK_EN_24M_N & ~div_q[0] & ~div_q[2] & ~r1hb_q;

endmodule

// File: tb/tb_neo_clkgen_sync.sv
// Directed bench for neo_clkgen_sync: a behavioural model predicts enables and
// queues the expected level outputs for comparison after each clock edge.
module tb_neo_clkgen_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic en_p, en_n;
    logic clk_24m, clk_12m, clk_68k, clk_68kb, en_68k_p, en_68k_n;
    logic clk_6mb, clk_1hb, en_12m, en_12m_n, en_6mb, en_1hb;

    always #5 clk = ~clk;

    neo_clkgen_sync dut (
        .CLK          (clk),
        .nRESETP      (rst_n),
        .CLK_EN_24M_P (en_p),
        .CLK_EN_24M_N (en_n),
        .CLK_24M      (clk_24m),
        .CLK_12M      (clk_12m),
        .CLK_68KCLK   (clk_68k),
        .CLK_68KCLKB  (clk_68kb),
        .CLK_EN_68K_P (en_68k_p),
        .CLK_EN_68K_N (en_68k_n),
        .CLK_6MB      (clk_6mb),
        .CLK_1HB      (clk_1hb),
        .CLK_EN_12M   (en_12m),
        .CLK_EN_12M_N (en_12m_n),
        .CLK_EN_6MB   (en_6mb),
        .CLK_EN_1HB   (en_1hb)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [2:0] m_div;
    logic       m_r24, m_r68k, m_r1hb;
    logic [5:0] lvl_q[$];
    logic [5:0] prev_en;
    int cnt12, cnt68p, cnt6mb, cnt1hb;

    // {24M, 12M, 68KCLK, 68KCLKB, 6MB, 1HB}
    function automatic logic [5:0] obs_lvl();
        return {clk_24m, clk_12m, clk_68k, clk_68kb, clk_6mb, clk_1hb};
    endfunction

    // {12M, 12M_N, 6MB, 68K_P, 68K_N, 1HB}
    function automatic logic [5:0] obs_en();
        return {en_12m, en_12m_n, en_6mb, en_68k_p, en_68k_n, en_1hb};
    endfunction

    function automatic logic [5:0] model_lvl();
        return {m_r24, m_div[0], m_r68k, ~m_r68k, ~m_div[1], m_r1hb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div  = 3'b100;
        m_r24  = 1'b0;
        m_r68k = 1'b0;
        m_r1hb = 1'b0;
        prev_en = 6'b0;
        lvl_q.delete();
    endtask

    task automatic step(input logic p, input logic n);
        logic [5:0] exp_en, cur_en, exp_lvl;
        @(negedge clk);
        en_p = p;
        en_n = n;
        #1;
        exp_en = {n & ~m_div[0], n & m_div[0], n & m_div[1] & m_div[0],
                  p & ~m_r68k, p & m_r68k, n & ~m_div[0] & ~m_div[2] & ~m_r1hb};
        cur_en = obs_en();
        chk("enables", {26'b0, cur_en}, {26'b0, exp_en});
        chk("no_adjacent_pulse", {26'b0, prev_en & cur_en}, 32'd0);
        prev_en = cur_en;
        cnt12  += int'(en_12m);
        cnt68p += int'(en_68k_p);
        cnt6mb += int'(en_6mb);
        cnt1hb += int'(en_1hb);
        if (p) begin
            m_r24  = 1'b1;
            m_r68k = ~m_r68k;
        end
        if (n) begin
            m_r24 = 1'b0;
            if (!m_div[0]) m_r1hb = ~m_div[2];
            m_div = m_div + 3'd1;
        end
        lvl_q.push_back(model_lvl());
        @(posedge clk);
        #1;
        if (lvl_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp_lvl = lvl_q.pop_front();
            chk("levels", {26'b0, obs_lvl()}, {26'b0, exp_lvl});
        end
    endtask

    task automatic clear_counts();
        cnt12 = 0; cnt68p = 0; cnt6mb = 0; cnt1hb = 0;
    endtask

    task automatic first_scenario();
        step(1'b1, 1'b0);
        chk("en12_on_first_n_pending", {31'b0, clk_12m}, 32'd0);
        step(1'b0, 1'b1);
        chk("clk12_after_first_n", {31'b0, clk_12m}, 32'd1);
        chk("div_after_first_n", {29'b0, m_div}, 32'd5);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_p  = 1'b0;
        en_n  = 1'b0;
        model_reset();
        clear_counts();
        #2;
        chk("reset_levels", {26'b0, obs_lvl()}, {26'b0, 6'b000_110});
        chk("reset_enables", {26'b0, obs_en()}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 64 CLK of alternating P,N after reset
        clear_counts();
        first_scenario();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end
        chk("count_en_12m", cnt12, 32'd16);
        chk("count_en_68k_p", cnt68p, 32'd16);
        chk("count_en_6mb", cnt6mb, 32'd8);
        chk("count_en_1hb", cnt1hb, 32'd4);

        // Stall mid-period, then resume from frozen state
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        clear_counts();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("stall_no_pulses", cnt12 + cnt68p + cnt6mb + cnt1hb, 32'd0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end

        // Run until DIV==6, then assert reset between edges
        for (int i = 0; i < 40 && m_div != 3'd6; i++) begin
            step(1'b1, 1'b0);
            if (m_div != 3'd6) step(1'b0, 1'b1);
        end
        chk("reached_div6", {29'b0, m_div}, 32'd6);
        #2;
        en_p = 1'b0;
        en_n = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_levels", {26'b0, obs_lvl()}, {26'b0, 6'b000_110});
        chk("async_reset_enables_n", {26'b0, obs_en()}, 32'd0);
        en_p = 1'b1;
        en_n = 1'b0;
        #1;
        chk("async_reset_enables_p", {26'b0, obs_en()}, 32'd0);
        model_reset();
        @(negedge clk);
        en_p = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        first_scenario();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
